// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
// Signals: in_valid/in_ready/in_instr/flush from fetch; out_valid/out_ready, control bundle,
//          out_imm, register indices, out_illegal and ill_cnt towards execute.
// Modports: master = surrounding pipeline (drives fetch side, consumes bundle), slave = decode stage.
interface decode_stage_if #(
    parameter int XLEN      = 16,
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_instr;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_RegWrite;
    logic                 out_RegDst;
    logic                 out_ALUSrc1;
    logic                 out_ALUSrc2;
    logic                 out_MemWrite;
    logic                 out_MemToReg;
    logic                 out_Regsrc;
    logic [3:0]           out_ALUOp;
    logic [XLEN-1:0]      out_imm;
    logic [2:0]           out_rd;
    logic [2:0]           out_rs1;
    logic [2:0]           out_rs2;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;
    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_RegWrite, out_RegDst, out_ALUSrc1, out_ALUSrc2,
               out_MemWrite, out_MemToReg, out_Regsrc, out_ALUOp, out_imm,
               out_rd, out_rs1, out_rs2, out_illegal, ill_cnt
    );
    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_RegWrite, out_RegDst, out_ALUSrc1, out_ALUSrc2,
               out_MemWrite, out_MemToReg, out_Regsrc, out_ALUOp, out_imm,
               out_rd, out_rs1, out_rs2, out_illegal, ill_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered 16-bit instruction decode with load-use stall, flush and illegal counter
// Ports: clk, rst (sync, active-high); io_bus (decode_stage_if.slave) carries the fetch handshake
//        (in_valid/in_ready/in_instr/flush) and the execute handshake (out_valid/out_ready,
//        control bundle, out_imm, out_rd/rs1/rs2, out_illegal, ill_cnt).
module decode_stage #(
    parameter int XLEN      = 16,
    parameter int ILL_CNT_W = 8,
    parameter int HAZARD_EN = 1
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave io_bus
);
    logic [15:0]          w_instr;
    logic [3:0]           w_op;
    logic [2:0]           w_rs1;
    logic [2:0]           w_rs2;
    logic                 w_illegal;
    logic                 w_reads_rs1;
    logic                 w_reads_rs2;
    logic                 w_hazard;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [6:0]           w_ctl;
    logic [3:0]           w_alu_op;
    logic [XLEN-1:0]      w_imm;
    logic [XLEN-1:0]      w_imm6;
    logic [XLEN-1:0]      w_imm7;
    logic [XLEN-1:0]      w_imm9;
    logic                 r_valid;
    logic [6:0]           r_ctl;
    logic [3:0]           r_alu_op;
    logic [XLEN-1:0]      r_imm;
    logic [2:0]           r_rd;
    logic [2:0]           r_rs2;
    logic                 r_illegal;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    assign w_instr     = io_bus.in_instr;
    assign w_op        = w_instr[15:12];
    assign w_rs1       = w_instr[11:9];
    assign w_rs2       = w_instr[8:6];
    assign w_illegal   = w_op >= 4'hC;
    assign w_imm6      = {{(XLEN-6){w_instr[5]}}, w_instr[5:0]};
    assign w_imm7      = {{(XLEN-7){w_instr[6]}}, w_instr[6:0]};
    assign w_imm9      = {{(XLEN-9){w_instr[8]}}, w_instr[8:0]};
    assign w_reads_rs1 = !w_illegal;
    assign w_reads_rs2 = w_op == 4'h1 || w_op == 4'h2 || w_op == 4'h4 || w_op == 4'h6 || w_op == 4'h7;

    // w_ctl = {RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, Regsrc}
    always_comb begin
        w_ctl    = 7'b0011000;
        w_alu_op = 4'd0;
        w_imm    = '0;
        case (w_op)
            4'h0: begin w_ctl = 7'b1101010; w_imm = w_imm7; end
            4'h1: begin w_ctl = 7'b0001100; w_imm = w_imm7; end
            4'h2: w_ctl = 7'b1100001;
            4'h3: begin w_ctl = 7'b1101001; w_imm = w_imm6; end
            4'h4: begin w_ctl = 7'b1100001; w_alu_op = 4'd2; end
            4'h5: begin w_ctl = 7'b1101001; w_alu_op = 4'd2; w_imm = w_imm7; end
            4'h6: begin w_ctl = 7'b1100001; w_alu_op = 4'd3; end
            4'h7: begin w_ctl = 7'b1100001; w_alu_op = 4'd8; end
            4'h8: begin w_ctl = 7'b1101001; w_alu_op = 4'd4; w_imm = w_imm6; end
            4'h9: begin w_ctl = 7'b1101001; w_alu_op = 4'd5; w_imm = w_imm6; end
            4'hA: begin w_ctl = 7'b0000000; w_alu_op = 4'd6; w_imm = w_imm9; end
            4'hB: begin w_ctl = 7'b0000000; w_alu_op = 4'd7; w_imm = w_imm9; end
            default: w_ctl = 7'b0011000;
        endcase
    end

    // Only a held load (RegWrite & MemToReg) can create a load-use dependency.
    assign w_hazard   = (HAZARD_EN != 0) && r_valid && r_ctl[1] && r_ctl[6] && io_bus.in_valid &&
                        ((w_reads_rs1 && w_rs1 == r_rd) || (w_reads_rs2 && w_rs2 == r_rd));
    assign w_in_ready = !rst && !io_bus.flush && !w_hazard && (!r_valid || io_bus.out_ready);
    assign w_accept   = io_bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctl     <= 7'b0;
            r_alu_op  <= 4'd0;
            r_imm     <= '0;
            r_rd      <= 3'd0;
            r_rs2     <= 3'd0;
            r_illegal <= 1'b0;
            r_ill_cnt <= '0;
        end else if (io_bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_ctl     <= w_ctl;
            r_alu_op  <= w_alu_op;
            r_imm     <= w_imm;
            r_rd      <= w_rs1;
            r_rs2     <= w_rs2;
            r_illegal <= w_illegal;
            if (w_illegal && r_ill_cnt != '1)
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
        end else if (io_bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready     = w_in_ready;
    assign io_bus.out_valid    = r_valid;
    assign io_bus.out_RegWrite = r_ctl[6];
    assign io_bus.out_RegDst   = r_ctl[5];
    assign io_bus.out_ALUSrc1  = r_ctl[4];
    assign io_bus.out_ALUSrc2  = r_ctl[3];
    assign io_bus.out_MemWrite = r_ctl[2];
    assign io_bus.out_MemToReg = r_ctl[1];
    assign io_bus.out_Regsrc   = r_ctl[0];
    assign io_bus.out_ALUOp    = r_alu_op;
    assign io_bus.out_imm      = r_imm;
    assign io_bus.out_rd       = r_rd;
    assign io_bus.out_rs1      = r_rd;
    assign io_bus.out_rs2      = r_rs2;
    assign io_bus.out_illegal  = r_illegal;
    assign io_bus.ill_cnt      = r_ill_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage against a table-driven reference model
module tb_decode_stage;
    localparam int XLEN      = 16;
    localparam int ILL_CNT_W = 8;

    typedef logic [36:0] bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_instr = 16'h0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) bus ();
    decode_stage_if #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W)) bus_nh ();

    assign bus.in_valid     = in_valid;
    assign bus.in_instr     = in_instr;
    assign bus.flush        = flush;
    assign bus.out_ready    = out_ready;
    assign bus_nh.in_valid  = in_valid;
    assign bus_nh.in_instr  = in_instr;
    assign bus_nh.flush     = flush;
    assign bus_nh.out_ready = out_ready;

    decode_stage #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W), .HAZARD_EN(1)) dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );
    decode_stage #(.XLEN(XLEN), .ILL_CNT_W(ILL_CNT_W), .HAZARD_EN(0)) dut_nh (
        .clk(clk), .rst(rst), .io_bus(bus_nh)
    );

    // {RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, Regsrc} per opcode
    logic [6:0] ctl_tab [16] = '{7'b1101010, 7'b0001100, 7'b1100001, 7'b1101001,
                                 7'b1100001, 7'b1101001, 7'b1100001, 7'b1100001,
                                 7'b1101001, 7'b1101001, 7'b0000000, 7'b0000000,
                                 7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000};
    int alu_tab  [16] = '{0, 0, 0, 0, 2, 2, 3, 8, 4, 5, 6, 7, 0, 0, 0, 0};
    int immw_tab [16] = '{7, 7, 0, 6, 0, 7, 0, 0, 6, 6, 9, 9, 0, 0, 0, 0};

    int          n_chk = 0;
    int          n_fail = 0;
    int          cnt = 0;
    bit          m_valid = 0;
    int          m_op = 0;
    logic [2:0]  m_rd = 3'd0;
    bundle_t     m_bundle = '0;
    bundle_t     q[$];

    function automatic bundle_t ref_bundle(logic [15:0] ins);
        int op = int'(ins[15:12]);
        int w = immw_tab[op];
        int v = int'(ins) & ((1 << w) - 1);
        if (w > 0 && v >= (1 << (w - 1))) v -= (1 << w);
        return {ctl_tab[op], 4'(alu_tab[op]), 16'(v), ins[11:9], ins[11:9], ins[8:6], op >= 12};
    endfunction

    function automatic bit reads(logic [15:0] ins, logic [2:0] r);
        int op = int'(ins[15:12]);
        return (op <= 11 && ins[11:9] == r) ||
               ((op == 1 || op == 2 || op == 4 || op == 6 || op == 7) && ins[8:6] == r);
    endfunction

    function automatic bundle_t dut_bundle();
        return {bus.out_RegWrite, bus.out_RegDst, bus.out_ALUSrc1, bus.out_ALUSrc2, bus.out_MemWrite,
                bus.out_MemToReg, bus.out_Regsrc, bus.out_ALUOp, bus.out_imm, bus.out_rd,
                bus.out_rs1, bus.out_rs2, bus.out_illegal};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] ins, input logic fl, input logic ordy);
        bit exp_rdy;
        @(negedge clk);
        rst = 1'b0; in_valid = v; in_instr = ins; flush = fl; out_ready = ordy;
        #2;
        exp_rdy = !fl && !(m_valid && m_op == 0 && v && reads(ins, m_rd)) && (!m_valid || ordy);
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("out_valid", bus.out_valid, m_valid);
        chk("ill_cnt", bus.ill_cnt, cnt);
        chk("held_bundle", dut_bundle(), m_bundle);
        if (fl) begin
            m_valid = 0;
            q.delete();
        end else if (v && exp_rdy) begin
            m_valid = 1;
            m_op = int'(ins[15:12]);
            m_rd = ins[11:9];
            m_bundle = ref_bundle(ins);
            q.push_back(m_bundle);
            if (ins[15:12] >= 4'hC && cnt < (1 << ILL_CNT_W) - 1) cnt++;
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_instr = 16'(($urandom)); flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_in_ready", bus.in_ready, 0);
        m_valid = 0; m_op = 0; m_rd = 3'd0; m_bundle = '0; cnt = 0;
        q.delete();
    endtask

    // Scoreboard monitor: one expected bundle is consumed per execute handshake.
    always @(negedge clk) begin
        #3;
        if (!rst && !flush && bus.out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got bundle %0h expected none", dut_bundle());
            end else begin
                chk("sb_bundle", dut_bundle(), q.pop_front());
            end
        end
    end

    initial begin
        do_rst();
        step(0, 16'h0, 0, 1);
        for (int op = 0; op < 12; op++)
            step(1, {4'(op), 3'(op), 3'(op + 1), 6'($urandom)}, 0, 1);
        step(1, 16'h3A3F, 0, 1);
        step(1, 16'hA100, 0, 1);
        chk("addi_imm", bus.out_imm, 16'hFFFF);
        chk("addi_alu", bus.out_ALUOp, 0);
        chk("addi_rw", bus.out_RegWrite, 1);
        step(0, 16'h0, 0, 1);
        chk("beqz_imm", bus.out_imm, 16'hFF00);
        chk("beqz_alu", bus.out_ALUOp, 6);
        chk("beqz_rw", bus.out_RegWrite, 0);
        do_rst();
        step(1, 16'h0240, 0, 1);
        step(1, 16'h2040, 0, 1);
        chk("hz_in_ready", bus.in_ready, 0);
        chk("nh_in_ready", bus_nh.in_ready, 1);
        step(1, 16'h2040, 0, 1);
        chk("hz_bubble", bus.out_valid, 0);
        chk("nh_no_bubble", bus_nh.out_valid, 1);
        step(0, 16'h0, 0, 1);
        step(1, 16'h1A7F, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h2040, 0, 0);
            chk("stall_imm", bus.out_imm, 16'hFFFF);
            chk("stall_mw", bus.out_MemWrite, 1);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 300; i++)
            step(1, {4'hF, 12'($urandom)}, 0, 1);
        step(0, 16'h0, 0, 1);
        chk("ill_sat", bus.ill_cnt, 255);
        chk("ill_flags", {bus.out_illegal, bus.out_RegWrite, bus.out_MemWrite, bus.out_ALUSrc1, bus.out_ALUSrc2}, 5'b10011);
        step(1, 16'h3A3F, 0, 0);
        step(1, 16'h2040, 1, 1);
        chk("flush_in_ready", bus.in_ready, 0);
        step(0, 16'h0, 0, 1);
        chk("flush_bubble", bus.out_valid, 0);
        for (int i = 0; i < 600; i++)
            step($urandom_range(3) != 0, 16'($urandom), $urandom_range(19) == 0, $urandom_range(3) != 0);
        step(1, 16'h3A3F, 0, 1);
        do_rst();
        step(0, 16'h0, 0, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_cnt", bus.ill_cnt, 0);
        chk("rst_bundle", dut_bundle(), 0);
        step(0, 16'h0, 0, 1);
        step(0, 16'h0, 0, 1);
        chk("sb_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
